// File: rtl/battle_scheduler.sv
// Purpose: arbitrates player/NPC strikes onto one resolution path, runs anim/cooldown timing, keeps health and death flags.
// Latency: grant in ARB -> anim for HIT_FRAMES cycles -> one RES cycle; hp and death flags visible the cycle after RES.
// Backpressure: none; attack requests are levels sampled only in ARB while the fighter is ready, ignored otherwise.
module battle_scheduler #(
    parameter int MAX_HP     = 100,
    parameter int HP_W       = 7,
    parameter int PLAYER_DMG = 10,
    parameter int NPC_DMG    = 5,
    parameter int HIT_FRAMES = 8,
    parameter int COOLDOWN   = 30
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            battle_l,
    input  logic            start_l,
    input  logic            player_atk,
    input  logic            npc_atk,
    input  logic            player_hit_ok,
    input  logic            npc_hit_ok,
    output logic [HP_W-1:0] player_hp,
    output logic [HP_W-1:0] npc_hp,
    output logic            player_anim,
    output logic            npc_anim,
    output logic            player_ready,
    output logic            npc_ready,
    output logic            Player_Dead,
    output logic            NPC_Dead
);

    localparam int CD_W = $clog2(COOLDOWN + 1);
    localparam int FR_W = $clog2(HIT_FRAMES + 1);

    localparam logic [HP_W-1:0] HP_FULL   = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0] P_DMG     = HP_W'(PLAYER_DMG);
    localparam logic [HP_W-1:0] N_DMG     = HP_W'(NPC_DMG);
    localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN);
    localparam logic [FR_W-1:0] FR_LAST   = FR_W'(HIT_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_P_ANIM,
        S_N_ANIM,
        S_P_RES,
        S_N_RES,
        S_DEAD
    } state_t;

    state_t          state, state_nxt;
    logic [FR_W-1:0] frame_cnt;
    logic [CD_W-1:0] player_cd, npc_cd;
    logic            pri_npc;      // 1: NPC wins the next tie
    logic            player_req, npc_req, tie_grant;
    logic            p_res_upd, n_res_upd;
    logic [HP_W-1:0] npc_hp_res, player_hp_res;

    // Health after the strike in RES: saturating subtract, only if the striker's hit landed.
    assign npc_hp_res    = !player_hit_ok ? npc_hp :
                           (npc_hp > P_DMG) ? (npc_hp - P_DMG) : '0;
    assign player_hp_res = !npc_hit_ok ? player_hp :
                           (player_hp > N_DMG) ? (player_hp - N_DMG) : '0;

    // A RES cycle only commits if the battle is still running; otherwise the strike is abandoned.
    assign p_res_upd = (state == S_P_RES) && battle_l;
    assign n_res_upd = (state == S_N_RES) && battle_l;

    assign player_ready = (player_cd == '0) && (state != S_IDLE) && (state != S_DEAD);
    assign npc_ready    = (npc_cd == '0)    && (state != S_IDLE) && (state != S_DEAD);
    assign player_req   = player_atk && player_ready;
    assign npc_req      = npc_atk && npc_ready;
    assign player_anim  = (state == S_P_ANIM);
    assign npc_anim     = (state == S_N_ANIM);

    // Next-state: arbitration, animation timing, resolution; battle_l low pulls any active state to IDLE.
    always_comb begin
        state_nxt = state;
        tie_grant = 1'b0;
        case (state)
            S_IDLE: begin
                if (battle_l) state_nxt = S_ARB;
            end
            S_ARB: begin
                tie_grant = player_req && npc_req;
                if (player_req && (!npc_req || !pri_npc)) state_nxt = S_P_ANIM;
                else if (npc_req)                         state_nxt = S_N_ANIM;
            end
            S_P_ANIM: begin
                if (frame_cnt == FR_LAST) state_nxt = S_P_RES;
            end
            S_N_ANIM: begin
                if (frame_cnt == FR_LAST) state_nxt = S_N_RES;
            end
            S_P_RES: begin
                state_nxt = (npc_hp_res == '0) ? S_DEAD : S_ARB;
            end
            S_N_RES: begin
                state_nxt = (player_hp_res == '0) ? S_DEAD : S_ARB;
            end
            S_DEAD: begin
                state_nxt = S_DEAD;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (state != S_IDLE && !battle_l) begin
            state_nxt = S_IDLE;
            tie_grant = 1'b0;
        end
    end

    // State, counters, health, priority and death flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            frame_cnt   <= '0;
            player_cd   <= '0;
            npc_cd      <= '0;
            player_hp   <= HP_FULL;
            npc_hp      <= HP_FULL;
            pri_npc     <= 1'b0;
            Player_Dead <= 1'b0;
            NPC_Dead    <= 1'b0;
        end else begin
            state <= state_nxt;

            // Frame counter restarts on every anim entry and runs while the anim state persists.
            if (state_nxt == state && (state == S_P_ANIM || state == S_N_ANIM))
                frame_cnt <= frame_cnt + 1'b1;
            else
                frame_cnt <= '0;

            // Cooldowns: cleared in IDLE, reloaded on resolution, otherwise count down to zero.
            if (state == S_IDLE)          player_cd <= '0;
            else if (p_res_upd)           player_cd <= CD_LOAD;
            else if (player_cd != '0)     player_cd <= player_cd - 1'b1;

            if (state == S_IDLE)          npc_cd <= '0;
            else if (n_res_upd)           npc_cd <= CD_LOAD;
            else if (npc_cd != '0)        npc_cd <= npc_cd - 1'b1;

            if (state == S_IDLE && start_l) begin
                player_hp <= HP_FULL;
                npc_hp    <= HP_FULL;
            end
            if (p_res_upd) npc_hp    <= npc_hp_res;
            if (n_res_upd) player_hp <= player_hp_res;

            if (tie_grant) pri_npc <= ~pri_npc;

            // Flags are set only on the RES->DEAD transition and cleared on the way back to IDLE.
            if (state_nxt == S_IDLE) begin
                Player_Dead <= 1'b0;
                NPC_Dead    <= 1'b0;
            end else if (p_res_upd) begin
                NPC_Dead    <= (npc_hp_res == '0);
            end else if (n_res_upd) begin
                Player_Dead <= (player_hp_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_battle_scheduler.sv
// Purpose: directed self-checking bench for battle_scheduler (NPC_DMG overridden to 7).
// Latency: inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Backpressure: none; every wait on the DUT is bounded and a timeout counts as an error.
module tb_battle_scheduler;

    localparam int HIT = 8;
    localparam int CD  = 30;

    logic       Clk;
    logic       Reset;
    logic       battle_l, start_l;
    logic       player_atk, npc_atk, player_hit_ok, npc_hit_ok;
    logic [6:0] player_hp, npc_hp;
    logic       player_anim, npc_anim, player_ready, npc_ready;
    logic       Player_Dead, NPC_Dead;

    int checks;
    int errors;
    int n;

    battle_scheduler #(
        .MAX_HP(100), .HP_W(7), .PLAYER_DMG(10), .NPC_DMG(7),
        .HIT_FRAMES(HIT), .COOLDOWN(CD)
    ) dut (
        .Clk(Clk), .Reset(Reset), .battle_l(battle_l), .start_l(start_l),
        .player_atk(player_atk), .npc_atk(npc_atk),
        .player_hit_ok(player_hit_ok), .npc_hit_ok(npc_hit_ok),
        .player_hp(player_hp), .npc_hp(npc_hp),
        .player_anim(player_anim), .npc_anim(npc_anim),
        .player_ready(player_ready), .npc_ready(npc_ready),
        .Player_Dead(Player_Dead), .NPC_Dead(NPC_Dead)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One complete strike by the chosen fighter; returns in ARB (or DEAD) the cycle after RES.
    task automatic strike(input bit by_npc, input bit hit);
        int k;
        k = 0;
        while (!(by_npc ? npc_ready : player_ready) && k < 200) begin
            tick();
            k++;
        end
        check_eq("strike_ready_wait", by_npc ? int'(npc_ready) : int'(player_ready), 1);
        if (by_npc) begin npc_hit_ok = hit; npc_atk = 1'b1; end
        else        begin player_hit_ok = hit; player_atk = 1'b1; end
        tick();
        player_atk = 1'b0;
        npc_atk    = 1'b0;
        k = 0;
        while ((by_npc ? npc_anim : player_anim) && k < 50) begin
            tick();
            k++;
        end
        check_eq("strike_anim_len", k, HIT);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1; battle_l = 1'b0; start_l = 1'b0;
        player_atk = 1'b0; npc_atk = 1'b0; player_hit_ok = 1'b0; npc_hit_ok = 1'b0;
        tick();
        check_eq("rst_player_hp", player_hp, 100);
        check_eq("rst_npc_hp", npc_hp, 100);
        check_eq("rst_flags", {Player_Dead, NPC_Dead, player_anim, npc_anim, player_ready, npc_ready}, 0);
        Reset = 1'b0;

        // Single player strike: anim length, hp update timing, cooldown length.
        start_l = 1'b1; tick(); start_l = 1'b0;
        battle_l = 1'b1; tick();
        check_eq("arb_player_ready", player_ready, 1);
        player_atk = 1'b1; player_hit_ok = 1'b1; npc_hit_ok = 1'b1;
        tick();
        player_atk = 1'b0;
        n = 0;
        while (player_anim && n < 20) begin n++; tick(); end
        check_eq("t1_anim_cycles", n, 8);
        check_eq("t1_hp_in_res", npc_hp, 100);
        tick();
        check_eq("t1_hp_after_res", npc_hp, 90);
        n = 0;
        while (!player_ready && n < 50) begin n++; tick(); end
        check_eq("t1_ready_low_cycles", n, 30);

        // Tie arbitration: player first, NPC next; next tie goes to NPC. Misses do no damage.
        player_hit_ok = 1'b0; npc_hit_ok = 1'b0;
        player_atk = 1'b1; npc_atk = 1'b1;
        tick();
        check_eq("t2_tie1_player", {player_anim, npc_anim}, 2'b10);
        n = 0;
        while (!npc_anim && n < 40) begin n++; tick(); end
        check_eq("t2_npc_second", npc_anim, 1);
        check_eq("t2_miss_no_dmg", npc_hp, 90);
        check_eq("t2_miss_cd_loaded", player_ready, 0);
        player_atk = 1'b0; npc_atk = 1'b0;
        n = 0;
        while (!(player_ready && npc_ready && !player_anim && !npc_anim) && n < 200) begin n++; tick(); end
        check_eq("t2_both_ready_wait", player_ready & npc_ready, 1);
        player_atk = 1'b1; npc_atk = 1'b1;
        tick();
        check_eq("t2_tie2_npc", {player_anim, npc_anim}, 2'b01);
        player_atk = 1'b0; npc_atk = 1'b0;
        n = 0;
        while (npc_anim && n < 20) begin n++; tick(); end
        tick();
        check_eq("t2_player_hp", player_hp, 100);

        // Held request during cooldown: re-grant only after ready returns.
        player_hit_ok = 1'b1; player_atk = 1'b1;
        n = 0;
        while (!player_ready && n < 100) begin n++; tick(); end
        tick();
        n = 0;
        while (player_anim && n < 20) begin n++; tick(); end
        n = 0;
        while (!player_anim && n < 60) begin n++; tick(); end
        check_eq("t3_regrant_gap", n, 32);
        player_atk = 1'b0;
        n = 0;
        while (player_anim && n < 20) begin n++; tick(); end
        tick();
        check_eq("t3_npc_hp", npc_hp, 70);

        // Kill the NPC: 7 more landed strikes from 70.
        for (int i = 0; i < 7; i++) strike(1'b0, 1'b1);
        check_eq("t4_npc_hp_zero", npc_hp, 0);
        check_eq("t4_npc_dead", NPC_Dead, 1);
        check_eq("t4_player_dead", Player_Dead, 0);
        check_eq("t4_ready_in_dead", player_ready, 0);
        player_atk = 1'b1;
        repeat (5) tick();
        player_atk = 1'b0;
        check_eq("t4_dead_held", NPC_Dead, 1);
        check_eq("t4_no_anim_dead", player_anim, 0);
        battle_l = 1'b0; tick();
        check_eq("t4_flag_clear", NPC_Dead, 0);
        check_eq("t4_idle_ready", player_ready, 0);
        check_eq("t4_hp_retained", npc_hp, 0);

        // Kill the player with NPC_DMG=7: 14 strikes -> 2, 15th saturates to 0.
        start_l = 1'b1; tick(); start_l = 1'b0;
        check_eq("t5_reload_npc", npc_hp, 100);
        battle_l = 1'b1; tick();
        for (int i = 0; i < 14; i++) strike(1'b1, 1'b1);
        check_eq("t5_player_hp_2", player_hp, 2);
        strike(1'b1, 1'b1);
        check_eq("t5_player_hp_sat", player_hp, 0);
        check_eq("t5_player_dead", Player_Dead, 1);
        check_eq("t5_npc_not_dead", NPC_Dead, 0);
        start_l = 1'b1; tick(); start_l = 1'b0;
        check_eq("t5_start_ignored", player_hp, 0);
        battle_l = 1'b0; tick();
        check_eq("t5_flag_clear", Player_Dead, 0);

        // Abort on anim cycle 4: no damage, back to IDLE.
        start_l = 1'b1; tick(); start_l = 1'b0;
        battle_l = 1'b1; tick();
        check_eq("t6_cd_cleared_idle", npc_ready, 1);
        player_atk = 1'b1; player_hit_ok = 1'b1;
        tick();
        player_atk = 1'b0;
        repeat (3) tick();
        check_eq("t6_anim_cycle4", player_anim, 1);
        battle_l = 1'b0; tick();
        check_eq("t6_abort_anim", player_anim, 0);
        check_eq("t6_abort_ready", player_ready, 0);
        repeat (12) tick();
        check_eq("t6_abort_no_dmg", npc_hp, 100);

        // Reset mid-strike restores hp, clears outputs and priority.
        battle_l = 1'b1; tick();
        strike(1'b1, 1'b1);
        check_eq("t7_player_hp", player_hp, 93);
        n = 0;
        while (!(player_ready && npc_ready) && n < 200) begin n++; tick(); end
        player_atk = 1'b1; npc_atk = 1'b1;
        tick();
        check_eq("t7_tie_player", player_anim, 1);
        player_atk = 1'b0; npc_atk = 1'b0;
        tick(); tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        check_eq("t7_rst_player_hp", player_hp, 100);
        check_eq("t7_rst_outs", {Player_Dead, NPC_Dead, player_anim, npc_anim, player_ready, npc_ready}, 0);
        tick();
        check_eq("t7_both_ready", {player_ready, npc_ready}, 2'b11);
        player_atk = 1'b1; npc_atk = 1'b1;
        tick();
        check_eq("t7_pri_player", {player_anim, npc_anim}, 2'b10);
        player_atk = 1'b0; npc_atk = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
